// File: rtl/store_log_fifo_pkg.sv
// rtl/store_log_fifo_pkg.sv - shared constants and entry type for the store log FIFO
package store_log_fifo_pkg;

    localparam int ENTRY_W       = 64;
    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_CNT_W = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - DEPTH x 64 storage, synchronous write port, asynchronous read port
module fifo_ram
    import store_log_fifo_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  entry_t        wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output entry_t        rd_data_o
);

    // Contents are intentionally not reset; the read side masks them via out_valid.
    entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/store_log_fifo.sv
// rtl/store_log_fifo.sv - logs processor stores into a FIFO with sticky overflow and drop counter
module store_log_fifo
    import store_log_fifo_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    parameter  int CNT_W = DEFAULT_CNT_W,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_enable,
    input  logic [31:0]      address_to_mem,
    input  logic [31:0]      data_to_mem,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_addr,
    output logic [31:0]      out_data,
    output logic [LW-1:0]    level,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_count
);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic   full;
    logic   pop;
    logic   push_ok;
    logic   drop;
    entry_t head;
    entry_t wr_entry;

    assign full    = (level_q == LW'(DEPTH));
    assign pop     = out_valid && out_ready;
    // A full queue still accepts a store when the head leaves on the same edge.
    assign push_ok = write_enable && (!full || pop);
    assign drop    = write_enable && full && !pop;

    assign wr_entry = '{addr: address_to_mem, data: data_to_mem};

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push_ok, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
            if (!(&drop_q)) begin
                drop_d = drop_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    fifo_ram #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (push_ok),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_entry),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (head)
    );

    assign out_valid  = (level_q != '0);
    assign out_addr   = head.addr;
    assign out_data   = head.data;
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_store_log_fifo.sv
// tb/tb_store_log_fifo.sv - self-checking bench for store_log_fifo against a queue model
module tb_store_log_fifo;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        write_enable;
    logic [31:0] address_to_mem;
    logic [31:0] data_to_mem;
    logic        out_ready;

    logic        out_valid;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [3:0]  level;
    logic        overflow;
    logic [7:0]  drop_count;

    logic        s_out_valid;
    logic [31:0] s_out_addr;
    logic [31:0] s_out_data;
    logic [3:0]  s_level;
    logic        s_overflow;
    logic [1:0]  s_drop_count;

    int checks = 0;
    int errors = 0;

    logic [63:0] mq[$];
    int          drops;

    always #5 clk = ~clk;

    store_log_fifo #(.DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .write_enable(write_enable),
        .address_to_mem(address_to_mem), .data_to_mem(data_to_mem),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .level(level), .overflow(overflow),
        .drop_count(drop_count)
    );

    store_log_fifo #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .write_enable(write_enable),
        .address_to_mem(address_to_mem), .data_to_mem(data_to_mem),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_addr(s_out_addr),
        .out_data(s_out_data), .level(s_level), .overflow(s_overflow),
        .drop_count(s_drop_count)
    );

    function automatic int sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    // One clock of stimulus; the model applies the head removal before the append.
    task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rdy);
        bit pop, push;
        write_enable   = we;
        address_to_mem = a;
        data_to_mem    = d;
        out_ready      = rdy;
        pop  = (mq.size() != 0) && rdy;
        push = we && ((mq.size() < DEPTH) || pop);
        @(posedge clk);
        #1;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back({a, d});
        else if (we) drops++;
        write_enable = 1'b0;
        out_ready    = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        mq.delete();
        drops = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        write_enable = 1'b0; out_ready = 1'b0;
        address_to_mem = '0; data_to_mem = '0;
        mq.delete();
        drops = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drops: got %0d expected 0", drop_count); end
        reset = 1'b1;
    endtask

    task automatic test_single();
        cycle(1'b1, 32'h54, 32'h7, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b expected 1", out_valid); end
        checks++; if (out_addr !== 32'h54) begin errors++; $display("FAIL single_addr: got %0h expected 54", out_addr); end
        checks++; if (out_data !== 32'h7) begin errors++; $display("FAIL single_data: got %0h expected 7", out_data); end
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL single_level: got %0d expected 1", level); end
        cycle(1'b0, '0, '0, 1'b1);
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL single_pop_level: got %0d expected 0", level); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %0b expected 0", out_valid); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) cycle(1'b1, 32'h1000 + i, i, 1'b0);
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL ovf_level: got %0d expected 8", level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
        checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL ovf_drops: got %0d expected 1", drop_count); end
        checks++; if (s_drop_count !== 2'd1) begin errors++; $display("FAIL ovf_drops_w2: got %0d expected 1", s_drop_count); end
        for (int i = 1; i <= 8; i++) begin
            checks++; if (out_data !== 32'(i)) begin errors++; $display("FAIL ovf_drain_data: got %0h expected %0h", out_data, i); end
            checks++; if (out_addr !== 32'h1000 + i) begin errors++; $display("FAIL ovf_drain_addr: got %0h expected %0h", out_addr, 32'h1000 + i); end
            cycle(1'b0, '0, '0, 1'b1);
        end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL ovf_drain_level: got %0d expected 0", level); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'h2000 + i, 32'h200 + i, 1'b0);
        cycle(1'b1, 32'hA0, 32'hA, 1'b1);
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL fpp_level: got %0d expected 8", level); end
        checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL fpp_drops: got %0d expected 1", drop_count); end
        for (int i = 0; i < 8; i++) begin
            logic [31:0] exp_d;
            exp_d = (i < 7) ? 32'h201 + i : 32'hA;
            checks++; if (out_data !== exp_d) begin errors++; $display("FAIL fpp_drain: got %0h expected %0h", out_data, exp_d); end
            cycle(1'b0, '0, '0, 1'b1);
        end
    endtask

    task automatic test_saturate();
        pulse_reset();
        for (int i = 0; i < 13; i++) cycle(1'b1, 32'h3000 + i, i, 1'b0);
        checks++; if (s_drop_count !== 2'd3) begin errors++; $display("FAIL sat_drops_w2: got %0d expected 3", s_drop_count); end
        checks++; if (s_overflow !== 1'b1) begin errors++; $display("FAIL sat_overflow_w2: got %0b expected 1", s_overflow); end
        checks++; if (drop_count !== 8'd5) begin errors++; $display("FAIL sat_drops_w8: got %0d expected 5", drop_count); end
        checks++; if (s_level !== 4'd8) begin errors++; $display("FAIL sat_level_w2: got %0d expected 8", s_level); end
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h4000 + i, 32'h40 + i, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0b expected 0", out_valid); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL mid_level: got %0d expected 0", level); end
        checks++; if (s_level !== 4'd0) begin errors++; $display("FAIL mid_level_w2: got %0d expected 0", s_level); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        mq.delete();
        drops = 0;
        cycle(1'b1, 32'h60, 32'h11, 1'b0);
        checks++; if (out_data !== 32'h11) begin errors++; $display("FAIL mid_after_data: got %0h expected 11", out_data); end
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL mid_after_level: got %0d expected 1", level); end
    endtask

    task automatic test_empty_ready();
        cycle(1'b0, '0, '0, 1'b1);
        cycle(1'b0, '0, '0, 1'b1);
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL empty_pop_level: got %0d expected 0", level); end
        cycle(1'b1, 32'h70, 32'h22, 1'b1);
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL nobypass_level: got %0d expected 1", level); end
        checks++; if (out_data !== 32'h22) begin errors++; $display("FAIL nobypass_data: got %0h expected 22", out_data); end
        cycle(1'b1, 32'h71, 32'h23, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, '0, 1'b0);
            checks++; if (out_data !== 32'h22) begin errors++; $display("FAIL hold_data: got %0h expected 22", out_data); end
        end
        cycle(1'b0, '0, '0, 1'b1);
        checks++; if (out_data !== 32'h23) begin errors++; $display("FAIL hold_next: got %0h expected 23", out_data); end
        cycle(1'b0, '0, '0, 1'b1);
    endtask

    task automatic test_random();
        pulse_reset();
        for (int i = 0; i < 10000; i++) begin
            int push_pct;
            logic we, rdy;
            push_pct = ((i / 1000) % 3 == 0) ? 75 : (((i / 1000) % 3 == 1) ? 50 : 30);
            we  = ($urandom_range(99) < push_pct);
            rdy = ($urandom_range(99) < 50);
            cycle(we, $urandom, $urandom, rdy);
            checks++; if (level !== 4'(mq.size())) begin errors++; $display("FAIL rnd_level cyc %0d: got %0d expected %0d", i, level, mq.size()); end
            checks++; if (out_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc %0d: got %0b expected %0b", i, out_valid, mq.size() != 0); end
            if (mq.size() != 0) begin
                checks++; if ({out_addr, out_data} !== mq[0]) begin errors++; $display("FAIL rnd_head cyc %0d: got %0h expected %0h", i, {out_addr, out_data}, mq[0]); end
            end
            checks++; if (overflow !== (drops > 0)) begin errors++; $display("FAIL rnd_overflow cyc %0d: got %0b expected %0b", i, overflow, drops > 0); end
            checks++; if (drop_count !== 8'(sat(drops, 8))) begin errors++; $display("FAIL rnd_drops cyc %0d: got %0d expected %0d", i, drop_count, sat(drops, 8)); end
            checks++; if (s_drop_count !== 2'(sat(drops, 2))) begin errors++; $display("FAIL rnd_drops_w2 cyc %0d: got %0d expected %0d", i, s_drop_count, sat(drops, 2)); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_saturate();
        test_reset_mid();
        test_empty_ready();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
